pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Program-counter and fetch-control stage that consumes the 8-bit jump target produced by the jump lookup table.
- Holds the current instruction address and sequences it by increment, absolute jump, call or return.
- Contains a small return-address stack and a run/done state machine.
- Drives the instruction-memory address and tells the top level when the program has finished.

Parameters:
PC_W, 8, width of program counter and jump target
START_ADDR, 0, address loaded on reset and on every Start
STACK_DEPTH, 4, number of return-address entries (power of two, >=2)

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset_n  input  1  asynchronous active-low reset
Start  input  1  one-cycle pulse: begin/restart program at START_ADDR
Halt  input  1  decoded halt instruction at current Prog_ctr
Stall  input  1  freeze PC and stack this cycle
Jump_en  input  1  absolute jump to Jump_addr
Call_en  input  1  push return address, then jump to Jump_addr
Ret_en  input  1  pop return address into PC
Jump_addr  input  PC_W  target from jump lookup table (combinational, valid same cycle as enable)
Prog_ctr  output  PC_W  current fetch address (registered)
Fetch_valid  output  1  Prog_ctr is a live fetch address
Done  output  1  program finished (registered, level)
Stack_err  output  1  sticky stack overflow/underflow flag

Behaviour:
- Reset (Reset_n low, async): Prog_ctr=START_ADDR, state=IDLE, Fetch_valid=0, Done=0, Stack_err=0, stack pointer=0. Stack contents don't-care.
- States:
  - IDLE: Fetch_valid=0, Done=0.
  - RUN: Fetch_valid=1.
  - DONE: Fetch_valid=0, Done=1.
- All outputs are registered and reflect state after the edge.
- IDLE: Start=1 -> RUN next edge; Prog_ctr<=START_ADDR, sp<=0, Stack_err<=0. All other inputs ignored.
- RUN, per edge, fixed priority: Halt > Stall > Ret_en > Call_en > Jump_en > increment.
  - Halt: -> DONE; Prog_ctr holds. Halt is honoured even when Stall=1.
  - Stall (no Halt): Prog_ctr, sp and stack unchanged.
  - Ret_en with sp>0: Prog_ctr<=stack[sp-1], sp<=sp-1.
  - Ret_en with sp==0 (underflow): Stack_err<=1, -> DONE, Prog_ctr holds.
  - Call_en with sp<STACK_DEPTH: stack[sp]<=Prog_ctr+1 (mod 2^PC_W), sp<=sp+1, Prog_ctr<=Jump_addr.
  - Call_en with sp==STACK_DEPTH (overflow): Stack_err<=1, -> DONE, Prog_ctr holds, no push.
  - Jump_en: Prog_ctr<=Jump_addr.
  - Otherwise: Prog_ctr<=Prog_ctr+1, wrapping 2^PC_W-1 -> 0 with no flag.
- Start while in RUN is ignored, so a program cannot be restarted mid-run except via reset.
- DONE: Prog_ctr holds; control inputs ignored. Start=1 -> RUN with the same reinitialisation as from IDLE (Stall ignored); Done drops the same edge.
- Stack_err is sticky until Start or reset.
- sp width is clog2(STACK_DEPTH)+1 so that "full" is representable.
- Latency: a control input sampled at edge N is visible on Prog_ctr after edge N.
- Reset asserted mid-RUN: immediate return to reset values with no pending push/pop completing.

Test Plan:
- Reset, Start pulse, no controls for 5 cycles -> Prog_ctr 0,1,2,3,4; Fetch_valid=1 from first RUN cycle; Done=0.
- At PC=3 assert Jump_en with Jump_addr=8'h40 -> next Prog_ctr=0x40, then 0x41; with Jump_en+Call_en together, Call wins and pushes 0x04.
- Call at PC=0x10 to 0x80, then Ret at 0x82 -> PC 0x80,0x81,0x82,0x11; sp returns to 0.
- Five nested Calls with STACK_DEPTH=4 -> fifth sets Stack_err=1, Done=1, Prog_ctr frozen. Ret at sp=0 -> same error. Start -> clears Stack_err, PC=0.
- Preload PC to 0xFE via Jump, then run: PC 0xFE,0xFF,0x00. Stall for 3 cycles at 0x00 -> PC held. Halt during Stall -> Done=1 next edge.
- Reset_n low asynchronously mid-cycle during RUN at PC=0x25 -> Prog_ctr=0, Fetch_valid=0, Done=0 without waiting for Clk.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter and fetch sequencer with a small return-address stack.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   start                        pulse: (re)start the program at START_ADDR from IDLE/DONE
//   halt, stall                  decoded halt at current PC, freeze PC/stack this cycle
//   jump_en, call_en, ret_en     control-flow requests (priority ret > call > jump)
//   jump_addr                    target from the jump lookup table, valid with the enable
//   prog_ctr                     registered fetch address
//   fetch_valid                  prog_ctr is a live fetch address (RUN state)
//   done                         program finished (DONE state)
//   stack_err                    sticky overflow/underflow flag, cleared by start or reset
module pc_fetch_ctrl #(
  parameter int unsigned           PC_W        = 8,
  parameter logic [PC_W-1:0]       START_ADDR  = '0,
  parameter int unsigned           STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            halt,
  input  logic            stall,
  input  logic            jump_en,
  input  logic            call_en,
  input  logic            ret_en,
  input  logic [PC_W-1:0] jump_addr,
  output logic [PC_W-1:0] prog_ctr,
  output logic            fetch_valid,
  output logic            done,
  output logic            stack_err
);

  // Index width for the stack array; the pointer carries one extra bit so "full" fits.
  localparam int unsigned AW   = $clog2(STACK_DEPTH);
  localparam int unsigned SP_W = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              err_d;
  logic              push_en;
  logic [PC_W-1:0]   push_data;
  logic [PC_W-1:0]   pc_inc;
  logic [AW-1:0]     wr_idx;
  logic [AW-1:0]     rd_idx;
  logic              sp_empty;
  logic              sp_full;

  logic [PC_W-1:0]   stack_q [STACK_DEPTH];

  assign pc_inc   = prog_ctr + PC_W'(1);
  assign wr_idx   = sp_q[AW-1:0];
  assign rd_idx   = AW'(sp_q - SP_W'(1));
  assign sp_empty = (sp_q == '0);
  assign sp_full  = (sp_q == SP_W'(STACK_DEPTH));

  // State, PC, pointer and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      prog_ctr    <= START_ADDR;
      sp_q        <= '0;
      stack_err   <= 1'b0;
      fetch_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      prog_ctr    <= pc_d;
      sp_q        <= sp_d;
      stack_err   <= err_d;
      fetch_valid <= (state_d == ST_RUN);
      done        <= (state_d == ST_DONE);
    end
  end

  // Stack storage; contents need no reset because the pointer gates every read.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_q[wr_idx] <= push_data;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    pc_d      = prog_ctr;
    sp_d      = sp_q;
    err_d     = stack_err;
    push_en   = 1'b0;
    push_data = pc_inc;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        // Start reinitialises from either idle state; everything else is ignored.
        if (start) begin
          state_d = ST_RUN;
          pc_d    = START_ADDR;
          sp_d    = '0;
          err_d   = 1'b0;
        end
      end

      ST_RUN: begin
        if (halt) begin
          state_d = ST_DONE;
        end else if (stall) begin
          // Hold PC and stack.
        end else if (ret_en) begin
          if (sp_empty) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            pc_d = stack_q[rd_idx];
            sp_d = sp_q - SP_W'(1);
          end
        end else if (call_en) begin
          if (sp_full) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            push_en = 1'b1;
            sp_d    = sp_q + SP_W'(1);
            pc_d    = jump_addr;
          end
        end else if (jump_en) begin
          pc_d = jump_addr;
        end else begin
          pc_d = pc_inc;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed, table-driven bench for pc_fetch_ctrl (PC_W=8, START_ADDR=0, STACK_DEPTH=4).
module tb_pc_fetch_ctrl;

  logic       clk;
  logic       reset_n;
  logic       start, halt, stall, jump_en, call_en, ret_en;
  logic [7:0] jump_addr;
  logic [7:0] prog_ctr;
  logic       fetch_valid, done, stack_err;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  typedef struct {
    string      name;
    logic       start, halt, stall, jmp, call, ret;
    logic [7:0] ja;
    logic [7:0] pc;
    logic       fv, dn, er;
  } vec_t;

  vec_t vecs[$];

  pc_fetch_ctrl #(
    .PC_W       (8),
    .START_ADDR (8'h00),
    .STACK_DEPTH(4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .halt       (halt),
    .stall      (stall),
    .jump_en    (jump_en),
    .call_en    (call_en),
    .ret_en     (ret_en),
    .jump_addr  (jump_addr),
    .prog_ctr   (prog_ctr),
    .fetch_valid(fetch_valid),
    .done       (done),
    .stack_err  (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input string nm, input logic st, input logic h, input logic s,
                     input logic j, input logic c, input logic r, input logic [7:0] ja,
                     input logic [7:0] pc, input logic fv, input logic dn, input logic er);
    vec_t v;
    v.name = nm; v.start = st; v.halt = h; v.stall = s; v.jmp = j; v.call = c; v.ret = r;
    v.ja = ja; v.pc = pc; v.fv = fv; v.dn = dn; v.er = er;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic st, input logic h, input logic s, input logic j,
                       input logic c, input logic r, input logic [7:0] ja);
    start = st; halt = h; stall = s; jump_en = j; call_en = c; ret_en = r; jump_addr = ja;
  endtask

  task automatic check(input string nm, input logic [7:0] pc, input logic fv,
                       input logic dn, input logic er);
    vec_cnt++;
    if (prog_ctr !== pc || fetch_valid !== fv || done !== dn || stack_err !== er) begin
      miss_cnt++;
      $display("FAIL %s: got pc=%02h fv=%0b done=%0b err=%0b, want pc=%02h fv=%0b done=%0b err=%0b",
               nm, prog_ctr, fetch_valid, done, stack_err, pc, fv, dn, er);
    end
  endtask

  initial begin
    //   name            st h  s  j  c  r  ja      pc     fv dn er
    add("start",        1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0);
    add("inc1",         0, 0, 0, 0, 0, 0, 8'h00, 8'h01, 1, 0, 0);
    add("inc2",         0, 0, 0, 0, 0, 0, 8'h00, 8'h02, 1, 0, 0);
    add("inc3",         0, 0, 0, 0, 0, 0, 8'h00, 8'h03, 1, 0, 0);
    add("jump40",       0, 0, 0, 1, 0, 0, 8'h40, 8'h40, 1, 0, 0);
    add("inc41",        0, 0, 0, 0, 0, 0, 8'h00, 8'h41, 1, 0, 0);
    add("start_in_run", 1, 0, 0, 0, 0, 0, 8'h00, 8'h42, 1, 0, 0);
    add("call_beats_jmp",0,0, 0, 1, 1, 0, 8'h50, 8'h50, 1, 0, 0);
    add("ret_to_43",    0, 0, 0, 0, 0, 1, 8'h00, 8'h43, 1, 0, 0);
    add("jump10",       0, 0, 0, 1, 0, 0, 8'h10, 8'h10, 1, 0, 0);
    add("call80",       0, 0, 0, 0, 1, 0, 8'h80, 8'h80, 1, 0, 0);
    add("inc81",        0, 0, 0, 0, 0, 0, 8'h00, 8'h81, 1, 0, 0);
    add("inc82",        0, 0, 0, 0, 0, 0, 8'h00, 8'h82, 1, 0, 0);
    add("ret_to_11",    0, 0, 0, 0, 0, 1, 8'h00, 8'h11, 1, 0, 0);
    add("nest1",        0, 0, 0, 0, 1, 0, 8'h20, 8'h20, 1, 0, 0);
    add("nest2",        0, 0, 0, 0, 1, 0, 8'h30, 8'h30, 1, 0, 0);
    add("nest3",        0, 0, 0, 0, 1, 0, 8'h40, 8'h40, 1, 0, 0);
    add("nest4",        0, 0, 0, 0, 1, 0, 8'h50, 8'h50, 1, 0, 0);
    add("overflow",     0, 0, 0, 0, 1, 0, 8'h60, 8'h50, 0, 1, 1);
    add("done_ignore",  0, 0, 0, 1, 0, 0, 8'h99, 8'h50, 0, 1, 1);
    add("restart_stall",1, 0, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0);
    add("underflow",    0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 1, 1);
    add("err_sticky",   0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 1);
    add("restart2",     1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0);
    add("jumpFE",       0, 0, 0, 1, 0, 0, 8'hFE, 8'hFE, 1, 0, 0);
    add("incFF",        0, 0, 0, 0, 0, 0, 8'h00, 8'hFF, 1, 0, 0);
    add("wrap00",       0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0);
    add("stall1",       0, 0, 1, 1, 0, 0, 8'h33, 8'h00, 1, 0, 0);
    add("stall2",       0, 0, 1, 0, 1, 0, 8'h33, 8'h00, 1, 0, 0);
    add("stall3",       0, 0, 1, 0, 0, 1, 8'h00, 8'h00, 1, 0, 0);
    add("halt_in_stall",0, 1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0);
    add("restart3",     1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0);
    add("callFF",       0, 0, 0, 1, 0, 0, 8'hFF, 8'hFF, 1, 0, 0);
    add("call_at_FF",   0, 0, 0, 0, 1, 0, 8'h24, 8'h24, 1, 0, 0);
    add("ret_wraps",    0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 1, 0, 0);
    add("jump24",       0, 0, 0, 1, 0, 0, 8'h24, 8'h24, 1, 0, 0);
    add("inc25",        0, 0, 0, 0, 0, 0, 8'h00, 8'h25, 1, 0, 0);

    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 8'h00);
    repeat (2) @(posedge clk);
    #1 check("reset", 8'h00, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1 check("idle_no_start", 8'h00, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].start, vecs[i].halt, vecs[i].stall, vecs[i].jmp,
            vecs[i].call, vecs[i].ret, vecs[i].ja);
      @(posedge clk);
      #1 check(vecs[i].name, vecs[i].pc, vecs[i].fv, vecs[i].dn, vecs[i].er);
    end

    // Async reset mid-cycle at PC=0x25 while a call is being requested.
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 0, 8'h77);
    #2 reset_n = 1'b0;
    #1 check("async_reset", 8'h00, 0, 0, 0);
    @(posedge clk);
    #1 check("reset_hold", 8'h00, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 8'h00);
    @(posedge clk);
    #1 check("post_reset_idle", 8'h00, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 8'h00);
    @(posedge clk);
    #1 check("post_reset_start", 8'h00, 1, 0, 0);
    // The call pending at reset must not have been pushed: pointer is empty.
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1, 8'h00);
    @(posedge clk);
    #1 check("post_reset_underflow", 8'h00, 0, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
